// File: rtl/pwm_status_reporter_pkg.sv
// -----------------------------------------------------------------------------
// pwm_status_reporter_pkg
// Shared constants and helpers for the PWM status reporter:
//   - frame header bytes and frame length
//   - baud divider computation (sys_clk cycles per UART bit)
//   - frame FSM state encoding
//   - checksum and frame byte selection helpers
// No ports (package).
// -----------------------------------------------------------------------------
package pwm_status_reporter_pkg;

  localparam logic [7:0] HDR0      = 8'h55;
  localparam logic [7:0] HDR1      = 8'hAA;
  localparam int         FRAME_LEN = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Truncating divide: cycles per UART bit.
  function automatic int calc_baud_div(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  // Modulo-256 sum of the three payload bytes.
  function automatic logic [7:0] calc_csum(input logic [7:0] func,
                                           input logic [7:0] busy,
                                           input logic [7:0] valid);
    return func + busy + valid;
  endfunction

  // Byte at position idx of the report frame.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [7:0] func,
                                            input logic [7:0] busy,
                                            input logic [7:0] valid);
    logic [7:0] b;
    b = HDR0;
    case (idx)
      3'd0:    b = HDR0;
      3'd1:    b = HDR1;
      3'd2:    b = func;
      3'd3:    b = busy;
      3'd4:    b = valid;
      3'd5:    b = calc_csum(func, busy, valid);
      default: b = HDR0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Serializes one byte as 8N1 (start, 8 data bits LSB first, stop), each bit
// BAUD_DIV sys_clk cycles long. tx_ready is also high during the final cycle
// of the stop bit so the next byte's start bit can follow with no gap.
// Ports:
//   sys_clk   in   clock, rising edge
//   sys_rst   in   synchronous active-high reset
//   tx_start  in   launch a byte (honoured only while tx_ready=1)
//   tx_data   in   byte to send, captured with tx_start
//   tx_ready  out  serializer can accept a byte this cycle
//   uart_txd  out  registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_byte_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_txd
);

  localparam int            CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    BIT_STOP = 4'd9;

  logic          r_active;
  logic [8:0]    r_shift;      // remaining data bits with the stop bit on top
  logic [3:0]    r_bit_idx;    // 0 = start, 1..8 = data, 9 = stop
  logic [CW-1:0] r_baud_cnt;
  logic          r_txd;
  logic          w_bit_end;
  logic          w_last_cycle;

  assign w_bit_end    = (r_baud_cnt == CNT_LAST);
  assign w_last_cycle = r_active && w_bit_end && (r_bit_idx == BIT_STOP);
  assign tx_ready     = !r_active || w_last_cycle;
  assign uart_txd     = r_txd;

  // Bit timing and shift register; a start in the last stop cycle chains bytes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_active   <= 1'b0;
      r_shift    <= 9'h1FF;
      r_bit_idx  <= 4'd0;
      r_baud_cnt <= '0;
      r_txd      <= 1'b1;
    end else if (tx_start && tx_ready) begin
      r_active   <= 1'b1;
      r_shift    <= {1'b1, tx_data};
      r_bit_idx  <= 4'd0;
      r_baud_cnt <= '0;
      r_txd      <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud_cnt <= '0;
        if (r_bit_idx == BIT_STOP) begin
          r_active <= 1'b0;
          r_txd    <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_txd     <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_baud_cnt <= r_baud_cnt + CW'(1);
      end
    end else begin
      r_txd <= 1'b1;
    end
  end

endmodule

// File: rtl/pwm_status_reporter.sv
// -----------------------------------------------------------------------------
// pwm_status_reporter
// Sends a 6-byte UART status frame (55 AA FUNC BUSY VALID CSUM) whenever a
// command packet arrives or, with EVT_EN=1, whenever pwm_valid changes.
// A trigger arriving while a frame is in flight is held in one pending slot
// and serviced straight from DONE with a fresh busy/valid snapshot.
// Ports:
//   sys_clk    in   clock, rising edge
//   sys_rst    in   synchronous active-high reset
//   pwm_busy   in   per-channel busy status
//   pwm_valid  in   per-channel end-of-pattern flags
//   pack_done  in   one-cycle pulse: command packet received
//   func_reg   in   function byte, valid with pack_done
//   uart_txd   out  8N1 serial line, idles high
//   tx_busy    out  high from LOAD until the last stop bit ends
//   frame_done out  one-cycle pulse in the DONE state
// -----------------------------------------------------------------------------
module pwm_status_reporter
  import pwm_status_reporter_pkg::*;
#(
  parameter int _NUM_CHANNELS = 4,
  parameter int CLK_FREQ      = 50_000_000,
  parameter int UART_BPS      = 115200,
  parameter bit EVT_EN        = 1'b1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [_NUM_CHANNELS-1:0] pwm_busy,
  input  logic [_NUM_CHANNELS-1:0] pwm_valid,
  input  logic                     pack_done,
  input  logic [7:0]               func_reg,
  output logic                     uart_txd,
  output logic                     tx_busy,
  output logic                     frame_done
);

  localparam int         BAUD_DIV = calc_baud_div(CLK_FREQ, UART_BPS);
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_t                   r_state;
  logic [2:0]               r_byte_idx;   // byte currently on the line
  logic [7:0]               r_func;
  logic [7:0]               r_busy_snap;
  logic [7:0]               r_valid_snap;
  logic                     r_pending;
  logic [7:0]               r_pend_func;
  logic                     r_tx_busy;
  logic                     r_frame_done;
  logic [_NUM_CHANNELS-1:0] r_valid_q;

  logic       w_event;
  logic       w_trig;
  logic [7:0] w_trig_func;
  logic [7:0] w_done_func;
  logic       w_tx_start;
  logic       w_tx_ready;
  logic [2:0] w_next_idx;
  logic [7:0] w_tx_data;

  assign w_event     = EVT_EN && (pwm_valid != r_valid_q);
  assign w_trig      = pack_done | w_event;
  // pack_done wins over a simultaneous event; an event alone reports FUNC 0.
  assign w_trig_func = pack_done ? func_reg : 8'h00;
  // Leaving DONE: a fresh pack_done overrides whatever FUNC is pending.
  assign w_done_func = pack_done ? func_reg : (r_pending ? r_pend_func : 8'h00);

  // Chooses which frame byte to launch and when the serializer may take it.
  always_comb begin
    w_tx_start = 1'b0;
    w_next_idx = 3'd0;
    case (r_state)
      ST_LOAD: begin
        w_tx_start = w_tx_ready;
        w_next_idx = 3'd0;
      end
      ST_SEND: begin
        w_tx_start = w_tx_ready && (r_byte_idx != LAST_IDX);
        w_next_idx = r_byte_idx + 3'd1;
      end
      default: begin
        w_tx_start = 1'b0;
        w_next_idx = 3'd0;
      end
    endcase
    w_tx_data = frame_byte(w_next_idx, r_func, r_busy_snap, r_valid_snap);
  end

  // Previous pwm_valid, used for change detection.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_valid_q <= '0;
    end else begin
      r_valid_q <= pwm_valid;
    end
  end

  // Frame FSM with pending-trigger slot and registered status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_byte_idx   <= 3'd0;
      r_func       <= 8'h00;
      r_busy_snap  <= 8'h00;
      r_valid_snap <= 8'h00;
      r_pending    <= 1'b0;
      r_pend_func  <= 8'h00;
      r_tx_busy    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            r_func    <= w_trig_func;
            r_tx_busy <= 1'b1;
            r_state   <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          r_busy_snap  <= 8'(pwm_busy);
          r_valid_snap <= 8'(pwm_valid);
          r_byte_idx   <= 3'd0;
          if (w_tx_ready) begin
            r_state <= ST_SEND;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_SEND: begin
          // tx_ready here marks the final cycle of the current stop bit.
          if (w_tx_ready) begin
            if (r_byte_idx == LAST_IDX) begin
              r_tx_busy    <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
            end
          end else begin
            r_state <= ST_SEND;
          end
        end
        ST_DONE: begin
          if (r_pending || w_trig) begin
            r_func    <= w_done_func;
            r_tx_busy <= 1'b1;
            r_state   <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx_busy <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase

      // One pending slot: first trigger claims it, later pack_done rewrites FUNC.
      if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
        r_pending <= 1'b0;
      end else if (w_trig && (!r_pending || pack_done)) begin
        r_pending   <= 1'b1;
        r_pend_func <= w_trig_func;
      end
    end
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_byte_tx (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .tx_start (w_tx_start),
    .tx_data  (w_tx_data),
    .tx_ready (w_tx_ready),
    .uart_txd (uart_txd)
  );

  assign tx_busy    = r_tx_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pwm_status_reporter.sv
// -----------------------------------------------------------------------------
// tb_pwm_status_reporter
// Two instances share the stimulus: u_slow at default parameters (434-cycle
// bits) and u_fast with a 10-cycle bit. Only one is out of reset at a time.
// A bench-side UART model predicts the line level in every cycle of a frame.
// -----------------------------------------------------------------------------
module tb_pwm_status_reporter;

  logic       clk = 1'b0;
  logic       rst_slow, rst_fast, pack_done;
  logic [7:0] func_reg;
  logic [3:0] pwm_busy, pwm_valid;
  logic       txd_slow, busy_slow, done_slow;
  logic       txd_fast, busy_fast, done_fast;
  logic       sel_slow;
  logic       txd_s, busy_s, done_s;
  int         div;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  assign txd_s  = sel_slow ? txd_slow  : txd_fast;
  assign busy_s = sel_slow ? busy_slow : busy_fast;
  assign done_s = sel_slow ? done_slow : done_fast;

  pwm_status_reporter u_slow (
    .sys_clk(clk), .sys_rst(rst_slow), .pwm_busy(pwm_busy), .pwm_valid(pwm_valid),
    .pack_done(pack_done), .func_reg(func_reg),
    .uart_txd(txd_slow), .tx_busy(busy_slow), .frame_done(done_slow)
  );

  pwm_status_reporter #(
    ._NUM_CHANNELS(4), .CLK_FREQ(1_000_000), .UART_BPS(100_000), .EVT_EN(1'b1)
  ) u_fast (
    .sys_clk(clk), .sys_rst(rst_fast), .pwm_busy(pwm_busy), .pwm_valid(pwm_valid),
    .pack_done(pack_done), .func_reg(func_reg),
    .uart_txd(txd_fast), .tx_busy(busy_fast), .frame_done(done_fast)
  );

  typedef struct {
    logic            pack;
    logic [7:0]      func;
    logic [3:0]      busy;
    logic [3:0]      valid;
    logic [0:5][7:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  // Called at the negedge where the trigger is presented. Checks fall latency,
  // every cycle of the 60-bit frame, decoded bytes and the frame_done cycle.
  // Optional pack_done pulses are injected at frame cycles inj_a / inj_b.
  task automatic capture(input string nm, input logic [0:5][7:0] exp,
                         input int inj_a, input logic [7:0] fa,
                         input int inj_b, input logic [7:0] fb);
    int              lat;
    int              bad;
    int              b;
    int              k;
    logic            eb;
    logic [0:5][7:0] got;
    got = '0;
    tick();
    pack_done = 1'b0;
    lat = 1;
    while (txd_s !== 1'b0 && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, lat, 2);
    bad = 0;
    for (int c = 0; c < 60 * div; c++) begin
      b = c / (10 * div);
      k = (c / div) % 10;
      if (k == 0)      eb = 1'b0;
      else if (k == 9) eb = 1'b1;
      else             eb = exp[b][k-1];
      if (txd_s !== eb || busy_s !== 1'b1 || done_s !== 1'b0) bad++;
      if (k >= 1 && k <= 8 && (c % div) == div / 2) got[b][k-1] = txd_s;
      pack_done = (c == inj_a) || (c == inj_b);
      func_reg  = (c == inj_b) ? fb : fa;
      tick();
    end
    pack_done = 1'b0;
    check({nm, "_bitcells"}, bad, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_byte%0d", nm, i), got[i], exp[i]);
    end
    check({nm, "_done_txd_busy"}, {done_s, txd_s, busy_s}, 3'b110);
  endtask

  task automatic idle_check(input string nm, input int ncyc);
    int bad;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (txd_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0) bad++;
    end
    check(nm, bad, 0);
  endtask

  initial begin
    vecs[0] = '{pack: 1'b1, func: 8'h01, busy: 4'h3, valid: 4'h0,
                exp: {8'h55, 8'hAA, 8'h01, 8'h03, 8'h00, 8'h04}};
    vecs[1] = '{pack: 1'b0, func: 8'h3C, busy: 4'h0, valid: 4'h8,
                exp: {8'h55, 8'hAA, 8'h00, 8'h00, 8'h08, 8'h08}};
    vecs[2] = '{pack: 1'b1, func: 8'h05, busy: 4'hC, valid: 4'h3,
                exp: {8'h55, 8'hAA, 8'h05, 8'h0C, 8'h03, 8'h14}};
    vecs[3] = '{pack: 1'b1, func: 8'hF0, busy: 4'hF, valid: 4'h3,
                exp: {8'h55, 8'hAA, 8'hF0, 8'h0F, 8'h03, 8'h02}};
    vecs[4] = '{pack: 1'b0, func: 8'hA5, busy: 4'h5, valid: 4'h0,
                exp: {8'h55, 8'hAA, 8'h00, 8'h05, 8'h00, 8'h05}};

    rst_slow = 1'b1; rst_fast = 1'b1; pack_done = 1'b0; func_reg = 8'h00;
    pwm_busy = 4'h0; pwm_valid = 4'h0; sel_slow = 1'b1; div = 434;
    repeat (4) tick();
    check("reset_slow", {txd_slow, busy_slow, done_slow}, 3'b100);
    check("reset_fast", {txd_fast, busy_fast, done_fast}, 3'b100);

    // Default parameters: 434-cycle bits, frame_done 26040 cycles after the fall.
    rst_slow = 1'b0;
    repeat (2) tick();
    pwm_busy = 4'h3; func_reg = 8'h01; pack_done = 1'b1;
    capture("slow_pack01", {8'h55, 8'hAA, 8'h01, 8'h03, 8'h00, 8'h04}, -1, 8'h01, -1, 8'h01);
    idle_check("slow_idle", 60);
    rst_slow = 1'b1;

    sel_slow = 1'b0; div = 10; rst_fast = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) begin
      pwm_busy  = vecs[i].busy;
      pwm_valid = vecs[i].valid;
      func_reg  = vecs[i].func;
      pack_done = vecs[i].pack;
      capture($sformatf("vec%0d", i), vecs[i].exp, -1, vecs[i].func, -1, vecs[i].func);
      idle_check($sformatf("vec%0d_no_extra", i), 50);
    end

    // Two pack_done pulses mid-frame: one extra frame carrying the later FUNC.
    pwm_busy = 4'h1; func_reg = 8'h11; pack_done = 1'b1;
    capture("pend_first", {8'h55, 8'hAA, 8'h11, 8'h01, 8'h00, 8'h12}, 100, 8'h02, 300, 8'h07);
    pwm_busy = 4'h6;
    capture("pend_second", {8'h55, 8'hAA, 8'h07, 8'h06, 8'h00, 8'h0D}, -1, 8'h07, -1, 8'h07);
    idle_check("pend_no_third", 80);

    // Reset during byte 3 with a pending trigger: line high, frame dropped.
    begin
      int lat;
      int bad;
      pwm_busy = 4'h2; func_reg = 8'h21; pack_done = 1'b1;
      tick();
      pack_done = 1'b0;
      lat = 1;
      while (txd_fast !== 1'b0 && lat < 20) begin
        tick();
        lat++;
      end
      check("rst_mid_latency", lat, 2);
      for (int c = 0; c < 31 * div + div / 2; c++) begin
        pack_done = (c == 50);
        tick();
      end
      pack_done = 1'b0;
      check("rst_mid_pre", {txd_fast, busy_fast}, 2'b01);
      rst_fast = 1'b1;
      tick();
      check("rst_mid_next", {txd_fast, busy_fast, done_fast}, 3'b100);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (txd_fast !== 1'b1 || busy_fast !== 1'b0 || done_fast !== 1'b0) bad++;
      end
      check("rst_mid_hold", bad, 0);
      rst_fast = 1'b0;
      idle_check("rst_mid_no_frame", 40 * div);
    end

    // pwm_valid nonzero at reset release is reported as an event.
    rst_fast = 1'b1; pwm_valid = 4'h5; pwm_busy = 4'h0; func_reg = 8'h99;
    repeat (3) tick();
    rst_fast = 1'b0;
    capture("post_rst_evt", {8'h55, 8'hAA, 8'h00, 8'h00, 8'h05, 8'h05}, -1, 8'h99, -1, 8'h99);
    idle_check("post_rst_idle", 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
